// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
// Instruction sequencer in front of the control unit. It owns the program
// counter, reads 12-bit words from a synchronous instruction memory, and
// presents the decoded fields to the execute stage.
//
// Handshake: an instruction is transferred on a rising edge where
// instr_valid=1 and exec_ready=1. While instr_valid=1 and exec_ready=0, the
// fields stay stable and pc does not move. exec_ready has no effect when
// instr_valid=0.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        begin/restart execution (sampled only in IDLE and HALTED)
//   exec_ready   execute stage accepts the presented instruction
//   imem_rdata   instruction word, valid the cycle after imem_rd_en
//   imem_addr    instruction address (always equals pc)
//   imem_rd_en   instruction memory read strobe
//   opcode/rd/rs1/rs2  instruction fields [11:9]/[8:6]/[5:3]/[2:0]
//   instr_valid  decoded fields valid, waiting for exec_ready
//   pc           address of the instruction being fetched or issued
//   busy         high in FETCH, WAIT and ISSUE
//   halted       high in HALTED
//   state_dbg    current FSM state encoding, for observation only
module fetch_decode_unit #(
   parameter int          PC_W      = 8,
   parameter int          PROG_LEN  = 256,
   parameter logic [11:0] HALT_WORD = 12'hFFF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            exec_ready,
   input  logic [11:0]     imem_rdata,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd_en,
   output logic [2:0]      opcode,
   output logic [2:0]      rd,
   output logic [2:0]      rs1,
   output logic [2:0]      rs2,
   output logic            instr_valid,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic [2:0]      state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_ISSUE  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [11:0]     ir_q, ir_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A halt word is never loaded into IR, so the fields keep
            // showing the last issued instruction.
            if (imem_rdata == HALT_WORD) begin
               state_d = S_HALTED;
            end else begin
               ir_d    = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (exec_ready) begin
               pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Every output is a decode of registered state.
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign imem_rd_en  = (state_q == S_FETCH);
   assign instr_valid = (state_q == S_ISSUE);
   assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
   assign halted      = (state_q == S_HALTED);
   assign opcode      = ir_q[11:9];
   assign rd          = ir_q[8:6];
   assign rs1         = ir_q[5:3];
   assign rs2         = ir_q[2:0];
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

   localparam logic [11:0] HALT = 12'hFFF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main DUT (PROG_LEN = 256)
   logic        start = 1'b0, exec_ready = 1'b0;
   logic [11:0] imem_rdata = '0;
   logic [7:0]  imem_addr, pc;
   logic        imem_rd_en, instr_valid, busy, halted;
   logic [2:0]  opcode, rd, rs1, rs2, state_dbg;

   // short-program DUT (PROG_LEN = 4) for the wrap check
   logic        start4 = 1'b0, exec_ready4 = 1'b0;
   logic [11:0] imem_rdata4 = '0;
   logic [7:0]  imem_addr4, pc4;
   logic        imem_rd_en4, instr_valid4, busy4, halted4;
   logic [2:0]  opcode4, rd4, rs14, rs24, state_dbg4;

   fetch_decode_unit dut (
      .clk(clk), .rst(rst), .start(start), .exec_ready(exec_ready),
      .imem_rdata(imem_rdata), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .instr_valid(instr_valid), .pc(pc), .busy(busy), .halted(halted),
      .state_dbg(state_dbg)
   );

   fetch_decode_unit #(.PROG_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .exec_ready(exec_ready4),
      .imem_rdata(imem_rdata4), .imem_addr(imem_addr4), .imem_rd_en(imem_rd_en4),
      .opcode(opcode4), .rd(rd4), .rs1(rs14), .rs2(rs24),
      .instr_valid(instr_valid4), .pc(pc4), .busy(busy4), .halted(halted4),
      .state_dbg(state_dbg4)
   );

   // ---------------- instruction memories ----------------
   logic [11:0] mem  [256];
   logic [11:0] mem4 [256];
   always @(posedge clk) begin
      if (imem_rd_en)  imem_rdata  <= mem[imem_addr];
      if (imem_rd_en4) imem_rdata4 <= mem4[imem_addr4];
   end

   // ---------------- scoreboard ----------------
   int vectors    = 0;
   int miscompares = 0;
   logic [19:0] exp_q[$];   // {pc, instruction}
   logic [19:0] exp4_q[$];
   logic [19:0] exp_e, exp4_e;

   always @(negedge clk) begin
      if (!rst && instr_valid && exec_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL issue_unexpected: got pc=%0d instr=%h, expected nothing", pc, {opcode, rd, rs1, rs2});
         end else begin
            exp_e = exp_q.pop_front();
            if ({pc, opcode, rd, rs1, rs2} !== exp_e) begin
               miscompares++;
               $display("FAIL issue: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                        pc, {opcode, rd, rs1, rs2}, exp_e[19:12], exp_e[11:0]);
            end
         end
      end
      if (!rst && instr_valid4 && exec_ready4) begin
         vectors++;
         if (exp4_q.size() == 0) begin
            miscompares++;
            $display("FAIL issue4_unexpected: got pc=%0d instr=%h, expected nothing", pc4, {opcode4, rd4, rs14, rs24});
         end else begin
            exp4_e = exp4_q.pop_front();
            if ({pc4, opcode4, rd4, rs14, rs24} !== exp4_e) begin
               miscompares++;
               $display("FAIL issue4: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                        pc4, {opcode4, rd4, rs14, rs24}, exp4_e[19:12], exp4_e[11:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) begin
         mem[i]  = HALT;
         mem4[i] = HALT;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_halted(input string name);
      for (int i = 0; i < 60 && halted !== 1'b1; i++) tick();
      vectors++;
      if (halted !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_halt_timeout: halted=%b, expected 1", name, halted);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      fill_halt();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if ({opcode, rd, rs1, rs2, instr_valid, imem_rd_en, busy, halted, pc, imem_addr, state_dbg} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got op=%0d rd=%0d rs1=%0d rs2=%0d v=%b re=%b busy=%b halt=%b pc=%0d st=%0d, expected all 0",
                  opcode, rd, rs1, rs2, instr_valid, imem_rd_en, busy, halted, pc, state_dbg);
      end
   endtask

   task automatic test_first();
      mem[0] = 12'b000_001_010_011;
      mem[1] = HALT;
      exec_ready = 1'b1;
      exp_q.push_back({8'd0, 12'b000_001_010_011});
      pulse_start();                       // cycle 1: FETCH
      vectors++;
      if (imem_rd_en !== 1'b1 || busy !== 1'b1 || imem_addr !== 8'd0) begin
         miscompares++;
         $display("FAIL first_fetch: got rd_en=%b busy=%b addr=%0d, expected 1 1 0", imem_rd_en, busy, imem_addr);
      end
      tick();                              // cycle 2: WAIT
      vectors++;
      if (imem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL first_wait: got rd_en=%b valid=%b, expected 0 0", imem_rd_en, instr_valid);
      end
      tick();                              // cycle 3: ISSUE
      vectors++;
      if (instr_valid !== 1'b1 || opcode !== 3'd0 || rd !== 3'd1 || rs1 !== 3'd2 || rs2 !== 3'd3) begin
         miscompares++;
         $display("FAIL first_issue: got v=%b op=%0d rd=%0d rs1=%0d rs2=%0d, expected 1 0 1 2 3",
                  instr_valid, opcode, rd, rs1, rs2);
      end
      tick();                              // cycle 4: next FETCH
      vectors++;
      if (pc !== 8'd1 || imem_rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL first_advance: got pc=%0d rd_en=%b, expected 1 1", pc, imem_rd_en);
      end
      wait_halted("first");
   endtask

   task automatic test_sequence();
      logic [11:0] w;
      fill_halt();
      for (int i = 0; i < 8; i++) begin
         w = {3'(i), 3'(7 - i), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
         mem[i] = w;
         exp_q.push_back({8'(i), w});
      end
      exec_ready = 1'b1;
      pulse_start();
      for (int c = 1; c <= 25; c++) begin
         vectors++;
         if (instr_valid !== ((c % 3 == 0) && (c <= 24))) begin
            miscompares++;
            $display("FAIL seq_spacing: cycle %0d valid=%b, expected %b", c, instr_valid, ((c % 3 == 0) && (c <= 24)));
         end
         tick();
      end
      wait_halted("seq");
      vectors++;
      if (pc !== 8'd8) begin
         miscompares++;
         $display("FAIL seq_halt_pc: got pc=%0d, expected 8", pc);
      end
   endtask

   task automatic test_stall();
      logic [11:0] a, b;
      fill_halt();
      a = 12'($urandom_range(0, 12'hFFE));
      b = 12'($urandom_range(0, 12'hFFE));
      mem[0] = a;
      mem[1] = b;
      exec_ready = 1'b0;
      pulse_start();
      tick();
      tick();                              // cycle 3: ISSUE, stalled
      for (int s = 0; s < 5; s++) begin
         vectors++;
         if (instr_valid !== 1'b1 || {opcode, rd, rs1, rs2} !== a || imem_rd_en !== 1'b0 || pc !== 8'd0) begin
            miscompares++;
            $display("FAIL stall_hold: cycle %0d got v=%b instr=%h re=%b pc=%0d, expected 1 %h 0 0",
                     s, instr_valid, {opcode, rd, rs1, rs2}, imem_rd_en, pc, a);
         end
         tick();
      end
      exp_q.push_back({8'd0, a});
      exp_q.push_back({8'd1, b});
      exec_ready = 1'b1;
      tick();
      vectors++;
      if (pc !== 8'd1 || instr_valid !== 1'b0 || imem_rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release: got pc=%0d v=%b re=%b, expected 1 0 1", pc, instr_valid, imem_rd_en);
      end
      wait_halted("stall");
   endtask

   task automatic test_halt();
      fill_halt();
      for (int i = 0; i < 4; i++) begin
         mem[i] = 12'($urandom_range(0, 12'hFFE));
         exp_q.push_back({8'(i), mem[i]});
      end
      exec_ready = 1'b1;
      pulse_start();
      wait_halted("halt");
      vectors++;
      if (busy !== 1'b0 || pc !== 8'd4 || instr_valid !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL halt_state: got busy=%b pc=%0d v=%b pending=%0d, expected 0 4 0 0",
                  busy, pc, instr_valid, exp_q.size());
      end
      vectors++;
      if ({opcode, rd, rs1, rs2} !== mem[3]) begin
         miscompares++;
         $display("FAIL halt_fields: got %h, expected %h", {opcode, rd, rs1, rs2}, mem[3]);
      end
      for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), mem[i]});
      pulse_start();
      vectors++;
      if (imem_addr !== 8'd0 || imem_rd_en !== 1'b1 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_restart: got addr=%0d re=%b halted=%b, expected 0 1 0", imem_addr, imem_rd_en, halted);
      end
      wait_halted("halt_again");
   endtask

   task automatic test_rst_mid_issue();
      fill_halt();
      mem[0] = 12'($urandom_range(1, 12'hFFE));
      exec_ready = 1'b0;
      pulse_start();
      tick();
      tick();                              // ISSUE, stalled
      vectors++;
      if (instr_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_issue: got valid=%b, expected 1", instr_valid);
      end
      rst = 1'b1;
      start = 1'b1;
      exec_ready = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      vectors++;
      if ({opcode, rd, rs1, rs2, instr_valid, imem_rd_en, busy, halted, pc, state_dbg} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got op=%0d rd=%0d rs1=%0d rs2=%0d v=%b re=%b busy=%b halt=%b pc=%0d st=%0d, expected all 0",
                  opcode, rd, rs1, rs2, instr_valid, imem_rd_en, busy, halted, pc, state_dbg);
      end
      tick();
      vectors++;
      if (state_dbg !== 3'd0 || busy !== 1'b0 || imem_rd_en !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_idle: got st=%0d busy=%b re=%b, expected 0 0 0", state_dbg, busy, imem_rd_en);
      end
      exp_q.push_back({8'd0, mem[0]});
      pulse_start();
      vectors++;
      if (imem_addr !== 8'd0 || imem_rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_restart: got addr=%0d re=%b, expected 0 1", imem_addr, imem_rd_en);
      end
      wait_halted("rst_mid");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         mem4[i] = 12'($urandom_range(0, 12'hFFE));
         exp4_q.push_back({8'(i), mem4[i]});
      end
      exp4_q.push_back({8'd0, mem4[0]});
      exec_ready4 = 1'b1;
      start4 = 1'b1;
      tick();                              // cycle 1
      start4 = 1'b0;
      repeat (12) tick();                  // cycle 13: refetch after 4th accept
      vectors++;
      if (pc4 !== 8'd0 || imem_rd_en4 !== 1'b1 || imem_addr4 !== 8'd0) begin
         miscompares++;
         $display("FAIL wrap_pc: got pc=%0d re=%b addr=%0d, expected 0 1 0", pc4, imem_rd_en4, imem_addr4);
      end
      repeat (3) tick();                   // cycle 16
      vectors++;
      if (exp4_q.size() != 0 || pc4 !== 8'd1) begin
         miscompares++;
         $display("FAIL wrap_refetch: got pending=%0d pc=%0d, expected 0 1", exp4_q.size(), pc4);
      end
      exec_ready4 = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_first();
      test_sequence();
      test_stall();
      test_halt();
      test_rst_mid_issue();
      test_wrap();
      repeat (4) tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
